bits_packer: RTL

//  Downstream stage of the bits unpacker: accepts variable-length fields (0..15 bits) per cycle
//  and packs them MSB-first into contiguous 32-bit words. Emits one word per completed 32 bits.
//  No backpressure is needed: each input adds at most 15 bits, so at most one word completes per cycle.

---
 rtl/bits_packer_pkg.sv | 17 +
 rtl/bits_pack_shift.sv | 42 ++++
 rtl/bits_packer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/bits_packer_pkg.sv
// bits_pkg: shared constants and state encoding for the bits_packer slice.
// Contents: WORD_W/LEN_W/DIN_W field geometry, CNT_W bit-count width, state_e FSM states.
// Latency/backpressure: n/a (declarations only).
package bits_pkg;

  localparam int WORD_W = 32;
  localparam int LEN_W  = 4;
  localparam int DIN_W  = (1 << LEN_W) - 1;
  // Holds 0..46, the largest cnt+L sum (31+15), without overflow.
  localparam int CNT_W  = 6;

  typedef enum logic [0:0] {
    ACCUM      = 1'b0,
    FLUSH_PEND = 1'b1
  } state_e;

endpackage

// File: rtl/bits_pack_shift.sv
// bits_pack_shift: combinational merge of one variable-length field into the pending word.
// Ports: i_push/i_len/i_data field in, i_acc/i_cnt pending state in;
//        o_word completed word, o_acc/o_cnt next pending state, o_done word-complete flag.
// Latency: 0 cycles (pure combinational); no backpressure.
module bits_pack_shift
  import bits_pkg::*;
(
  input  logic              i_push,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [DIN_W-1:0]  i_data,
  input  logic [WORD_W-1:0] i_acc,
  input  logic [CNT_W-1:0]  i_cnt,
  output logic [WORD_W-1:0] o_word,
  output logic [WORD_W-1:0] o_acc,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_done
);

  logic [LEN_W-1:0]    w_len;
  logic [DIN_W-1:0]    w_field;
  logic [CNT_W-1:0]    w_sum;
  logic [6:0]          w_shamt;
  logic [2*WORD_W-1:0] w_cat;

  // A cycle without pushin behaves exactly like a zero-length field.
  assign w_len   = i_push ? i_len : '0;
  // Keep only datain[L-1:0]; a shift of 15 leaves the whole mask set.
  assign w_field = i_data & ~({DIN_W{1'b1}} << w_len);
  assign w_sum   = i_cnt + CNT_W'(w_len);

  // Treat acc as the top half of a 64-bit window. The field's LSB lands at
  // bit 64-(cnt+L), so anything spilling past the word boundary falls into
  // the lower half already MSB-aligned as the fresh accumulator.
  assign w_shamt = 7'd64 - {1'b0, w_sum};
  assign w_cat   = {i_acc, {WORD_W{1'b0}}} | ((2*WORD_W)'(w_field) << w_shamt);

  assign o_done  = (w_sum >= CNT_W'(WORD_W));
  assign o_word  = w_cat[2*WORD_W-1:WORD_W];
  assign o_acc   = o_done ? w_cat[WORD_W-1:0] : w_cat[2*WORD_W-1:WORD_W];
  assign o_cnt   = o_done ? (w_sum - CNT_W'(WORD_W)) : w_sum;

endmodule

// File: rtl/bits_packer.sv
// bits_packer: packs 0..15-bit fields MSB-first into 32-bit words, one pushout per word.
// Ports: clock/reset (sync, active-high); pushin/lenin/datain field in; flush (only with
//        BITS_PACKER_FLUSH_EN) emits a partial word; pushout/dataout/validout registered word out.
// Latency: 1 cycle from completing push (or flush) to pushout; no backpressure (<=1 word/cycle).
module bits_packer
  import bits_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              pushin,
  input  logic [LEN_W-1:0]  lenin,
  input  logic [DIN_W-1:0]  datain,
`ifdef BITS_PACKER_FLUSH_EN
  input  logic              flush,
`endif
  output logic              pushout,
  output logic [WORD_W-1:0] dataout,
  output logic [CNT_W-1:0]  validout
);

  logic [WORD_W-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_pushout;
  logic [WORD_W-1:0] r_dataout;
  logic [CNT_W-1:0]  r_validout;

  logic [WORD_W-1:0] w_sh_acc_in;
  logic [CNT_W-1:0]  w_sh_cnt_in;
  logic [WORD_W-1:0] w_word;
  logic [WORD_W-1:0] w_acc;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_done;

  logic [WORD_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_pushout_nxt;
  logic [WORD_W-1:0] w_dataout_nxt;
  logic [CNT_W-1:0]  w_validout_nxt;

`ifdef BITS_PACKER_FLUSH_EN
  state_e r_state;
  state_e w_state_nxt;
  logic   r_flush_hold;
  logic   w_flush_hold_nxt;
  logic   w_flush_eff;

  // In FLUSH_PEND the registered leftover is being emitted this cycle, so
  // new input merges into an empty accumulator.
  assign w_sh_acc_in = (r_state == FLUSH_PEND) ? '0 : r_acc;
  assign w_sh_cnt_in = (r_state == FLUSH_PEND) ? '0 : r_cnt;
  // A flush seen while FLUSH_PEND was busy is replayed on the next ACCUM cycle.
  assign w_flush_eff = flush | r_flush_hold;
`else
  assign w_sh_acc_in = r_acc;
  assign w_sh_cnt_in = r_cnt;
`endif

  bits_pack_shift u_shift (
    .i_push (pushin),
    .i_len  (lenin),
    .i_data (datain),
    .i_acc  (w_sh_acc_in),
    .i_cnt  (w_sh_cnt_in),
    .o_word (w_word),
    .o_acc  (w_acc),
    .o_cnt  (w_cnt),
    .o_done (w_done)
  );

`ifdef BITS_PACKER_FLUSH_EN
  always_comb begin
    w_state_nxt      = r_state;
    w_flush_hold_nxt = r_flush_hold;
    w_acc_nxt        = w_acc;
    w_cnt_nxt        = w_cnt;
    w_pushout_nxt    = 1'b0;
    w_dataout_nxt    = r_dataout;
    w_validout_nxt   = r_validout;
    case (r_state)
      ACCUM: begin
        w_flush_hold_nxt = 1'b0;
        if (w_done) begin
          w_pushout_nxt  = 1'b1;
          w_dataout_nxt  = w_word;
          w_validout_nxt = CNT_W'(WORD_W);
          // Only one word can leave per cycle; the leftover goes out next.
          if (w_flush_eff && (w_cnt != '0)) begin
            w_state_nxt = FLUSH_PEND;
          end
        end else if (w_flush_eff && (w_cnt != '0)) begin
          w_pushout_nxt  = 1'b1;
          w_dataout_nxt  = w_acc;
          w_validout_nxt = w_cnt;
          w_acc_nxt      = '0;
          w_cnt_nxt      = '0;
        end
      end
      FLUSH_PEND: begin
        w_pushout_nxt    = 1'b1;
        w_dataout_nxt    = r_acc;
        w_validout_nxt   = r_cnt;
        w_flush_hold_nxt = flush;
        w_state_nxt      = ACCUM;
      end
      default: begin
        w_state_nxt = ACCUM;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ACCUM;
      r_flush_hold <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_hold <= w_flush_hold_nxt;
    end
  end
`else
  always_comb begin
    w_acc_nxt      = w_acc;
    w_cnt_nxt      = w_cnt;
    w_pushout_nxt  = w_done;
    w_dataout_nxt  = r_dataout;
    w_validout_nxt = r_validout;
    if (w_done) begin
      w_dataout_nxt  = w_word;
      w_validout_nxt = CNT_W'(WORD_W);
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_pushout  <= 1'b0;
      r_dataout  <= '0;
      r_validout <= '0;
    end else begin
      r_acc      <= w_acc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pushout  <= w_pushout_nxt;
      r_dataout  <= w_dataout_nxt;
      r_validout <= w_validout_nxt;
    end
  end

  assign pushout  = r_pushout;
  assign dataout  = r_dataout;
  assign validout = r_validout;

endmodule
